// File: rtl/ram_sweep_pkg.sv
// rtl/ram_sweep_pkg.sv - shared types for the ram_sweep block
//
// Holds the controller state encoding used by the top-level FSM.
package ram_sweep_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_sweep_if.sv
// rtl/ram_sweep_if.sv - user-side bus of the ram_sweep block
//
// Groups the manual access, mode control and display outputs.
//   wren/address/data   : manual write enable, address, write data
//   scan_en/clear_req   : scan mode request level, clear sequence request
//   q/q_addr            : registered read data and the address it belongs to
//   busy/wrap           : clear in progress, scan pointer wrap pulse
// master drives requests (board wrapper / bench), slave is the RAM block.
interface ram_sweep_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    import ram_sweep_pkg::*;

    logic              wren;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              scan_en;
    logic              clear_req;
    logic [DATA_W-1:0] q;
    logic [ADDR_W-1:0] q_addr;
    logic              busy;
    logic              wrap;

    modport master (
        output wren, address, data, scan_en, clear_req,
        input  q, q_addr, busy, wrap
    );

    modport slave (
        input  wren, address, data, scan_en, clear_req,
        output q, q_addr, busy, wrap
    );

endinterface

// File: rtl/ram_sweep_mem.sv
// rtl/ram_sweep_mem.sv - single-port synchronous RAM with write-through read
//
// Ports:
//   clock, resetn : clock and synchronous active-low reset (read register only)
//   we, addr      : write enable and the single shared address
//   wdata         : write data
//   rdata         : registered read data; a same-cycle write returns wdata
module ram_sweep_mem
    import ram_sweep_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    // Array is deliberately left out of reset so it maps onto block RAM;
    // the controller's clear sequence initialises it instead.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = we ? wdata : mem[addr];
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_sweep.sv
// rtl/ram_sweep.sv - parametrised RAM with hardware clear and auto-scan display
//
// Ports:
//   clock  : single rising-edge clock
//   resetn : synchronous active-low reset; restarts the clear sequence
//   bus    : ram_sweep_if slave (manual access, scan/clear control, q/q_addr,
//            busy, wrap)
// The FSM sequences CLEAR -> MANUAL <-> SCAN; the RAM itself lives in
// ram_sweep_mem and this file only muxes its address/data/enable.
module ram_sweep
    import ram_sweep_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DWELL  = 4
) (
    input  logic        clock,
    input  logic        resetn,
    ram_sweep_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    // DWELL=1 still needs a 1-bit counter; it simply never counts past 0.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic [ADDR_W-1:0] q_addr_q, q_addr_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wrap;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dwell_d   = dwell_q;
        mem_we    = 1'b0;
        mem_addr  = bus.address;
        mem_wdata = bus.data;
        q_addr_d  = bus.address;
        wrap      = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                // All user inputs are ignored; ptr rolls over to 0 on exit.
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                q_addr_d  = ptr_q;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_LAST) begin
                    state_d = ST_MANUAL;
                end
            end
            ST_MANUAL: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else begin
                    mem_we = bus.wren;
                    if (bus.scan_en) begin
                        state_d = ST_SCAN;
                        ptr_d   = '0;
                        dwell_d = '0;
                    end
                end
            end
            ST_SCAN: begin
                mem_addr = ptr_q;
                q_addr_d = ptr_q;
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (!bus.scan_en) begin
                    state_d = ST_MANUAL;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    wrap    = (ptr_q == ADDR_LAST);
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase

        // Whatever state we were in, a reset cycle must not disturb memory.
        if (!resetn) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            dwell_q  <= '0;
            q_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dwell_q  <= dwell_d;
            q_addr_q <= q_addr_d;
        end
    end

    ram_sweep_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock  (clock),
        .resetn (resetn),
        .we     (mem_we),
        .addr   (mem_addr),
        .wdata  (mem_wdata),
        .rdata  (mem_rdata)
    );

    assign bus.q      = mem_rdata;
    assign bus.q_addr = q_addr_q;
    assign bus.busy   = (state_q == ST_CLEAR);
    assign bus.wrap   = wrap;

endmodule

// File: tb/tb_ram_sweep.sv
// tb/tb_ram_sweep.sv - directed self-checking bench for ram_sweep
module tb_ram_sweep;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DWELL  = 4;
    localparam int DEPTH  = 32;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    ram_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_sweep #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DWELL  (DWELL)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int j;
        int wraps;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        resetn        = 1'b0;
        bus.wren      = 1'b0;
        bus.address   = '0;
        bus.data      = '0;
        bus.scan_en   = 1'b0;
        bus.clear_req = 1'b0;
        step();
        step();
        chk("reset_busy", 32'(bus.busy), 32'd1);
        chk("reset_q", 32'(bus.q), 32'd0);
        chk("reset_q_addr", 32'(bus.q_addr), 32'd0);
        chk("reset_wrap", 32'(bus.wrap), 32'd0);

        // Clear after reset: busy for 32 edges, q_addr follows the cleared word.
        resetn = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("init_busy", 32'(bus.busy), (k < DEPTH) ? 32'd1 : 32'd0);
            chk("init_q_addr", 32'(bus.q_addr), 32'(k - 1));
            chk("init_q", 32'(bus.q), 32'd0);
        end

        for (int i = 0; i < DEPTH; i++) begin
            bus.address = ADDR_W'(i);
            step();
            chk("init_read_q", 32'(bus.q), 32'd0);
            chk("init_read_q_addr", 32'(bus.q_addr), 32'(i));
        end

        // Manual write with write-through, then read back.
        bus.wren = 1'b1; bus.address = 5'h13; bus.data = 8'hA5;
        step();
        model[5'h13] = 8'hA5;
        chk("wr_thru_q", 32'(bus.q), 32'hA5);
        chk("wr_thru_q_addr", 32'(bus.q_addr), 32'h13);
        bus.wren = 1'b0; bus.address = 5'h12;
        step();
        chk("rd_12", 32'(bus.q), 32'h00);
        bus.address = 5'h13;
        step();
        chk("rd_13", 32'(bus.q), 32'hA5);

        // Preload then scan.
        bus.wren = 1'b1;
        bus.address = 5'h00; bus.data = 8'h11; step(); model[5'h00] = 8'h11;
        bus.address = 5'h01; bus.data = 8'h22; step(); model[5'h01] = 8'h22;
        bus.address = 5'h1F; bus.data = 8'h99; step(); model[5'h1F] = 8'h99;
        bus.wren = 1'b0; bus.address = 5'h05;
        bus.scan_en = 1'b1;
        step();
        chk("scan_entry_q_addr", 32'(bus.q_addr), 32'h05);
        wraps = 0;
        for (int c = 1; c <= 132; c++) begin
            // Writes attempted during scan must be dropped.
            bus.wren = (c >= 10 && c <= 12);
            bus.data = 8'h5A;
            bus.address = 5'h00;
            step();
            j = ((c - 1) / DWELL) % DEPTH;
            chk("scan_q_addr", 32'(bus.q_addr), 32'(j));
            chk("scan_q", 32'(bus.q), 32'(model[j]));
            chk("scan_wrap", 32'(bus.wrap),
                ((c % DWELL == DWELL - 1) && ((c / DWELL) % DEPTH == DEPTH - 1)) ? 32'd1 : 32'd0);
            if (c <= 128 && bus.wrap === 1'b1) wraps++;
        end
        chk("scan_wrap_count", 32'(wraps), 32'd1);
        bus.wren = 1'b0;
        bus.scan_en = 1'b0;
        step();
        bus.address = 5'h00;
        step();
        chk("scan_write_ignored", 32'(bus.q), 32'h11);
        chk("scan_exit_busy", 32'(bus.busy), 32'd0);

        // Clear request mid-scan with scan_en held.
        bus.scan_en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        chk("clr_busy_start", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("clr_busy", 32'(bus.busy), (k < DEPTH) ? 32'd1 : 32'd0);
        end
        step();
        chk("clr_manual_to_scan_busy", 32'(bus.busy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("clr_scan_q_addr", 32'(bus.q_addr), (c <= DWELL) ? 32'd0 : 32'd1);
            chk("clr_scan_q", 32'(bus.q), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        // Reset in the middle of a clear sequence.
        bus.scan_en = 1'b0;
        step();
        bus.wren = 1'b1; bus.address = 5'h1E; bus.data = 8'h77;
        step();
        chk("pre_rst_write", 32'(bus.q), 32'h77);
        bus.wren = 1'b0;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("mid_clear_q_addr", 32'(bus.q_addr), 32'd8);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd1);
        chk("mid_rst_q_addr", 32'(bus.q_addr), 32'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("rst_clr_busy", 32'(bus.busy), (k < DEPTH) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.address = ADDR_W'(i);
            step();
            chk("final_read_q", 32'(bus.q), 32'(model[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sweep.md
# ram_sweep

Parametrised single-port synchronous RAM block for the lab memory practicals, succeeding the fixed 32x8 LPM RAM used in the board-level exercise. Adds a hardware clear sequence after reset or on request, and an auto-scan mode that walks every address and presents each stored word for a programmable number of cycles. Sits between the switch/LED/seven-segment board wrapper and the user, driving the data and address display decoders from `q` and `q_addr`.

## Interface
- `DATA_W`, 8, word width in bits
- `ADDR_W`, 5, address width; depth DEPTH = 2**ADDR_W
- `DWELL`, 4, cycles each address is held in scan mode (>=1; board build uses ~25_000_000)

- `clock`  in  1  single clock, all logic on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `wren`  in  1  write enable, manual mode only
- `address`  in  ADDR_W  manual read/write address
- `data`  in  DATA_W  write data
- `scan_en`  in  1  level; high requests scan mode
- `clear_req`  in  1  level/pulse; starts a clear sequence
- `q`  out  DATA_W  registered read data
- `q_addr`  out  ADDR_W  address that `q` belongs to
- `busy`  out  1  high while clearing
- `wrap`  out  1  one-cycle pulse when scan pointer wraps DEPTH-1 -> 0

## Operation
- States: CLEAR, MANUAL, SCAN.
- CLEAR: internal pointer `ptr` from 0 to DEPTH-1, writes 0 to mem[ptr] each cycle; `busy`=1; `wren`, `scan_en`, `clear_req` ignored. After writing DEPTH-1 -> MANUAL.
- MANUAL: `wren`=1 writes `data` to mem[`address`]. Read every cycle from `address`; write-through (same-cycle write returns new `data`).
- MANUAL -> SCAN when `scan_en`=1 (and `clear_req`=0); `ptr`<=0, dwell counter<=0.
- SCAN: reads mem[`ptr`] every cycle; dwell counter 0..DWELL-1; at DWELL-1 counter->0 and `ptr` increments, DEPTH-1 wraps to 0 with `wrap`=1 that cycle. Writes ignored. `scan_en`=0 -> MANUAL next edge.
- `clear_req`=1 in MANUAL or SCAN -> CLEAR, `ptr`<=0; takes priority over `scan_en` and `wren` (no write that cycle).
- After CLEAR exits to MANUAL; if `scan_en` still high, SCAN entered on following edge.
- Address arithmetic modulo DEPTH; dwell counter width clog2(DWELL), DWELL=1 means advance every cycle.

## Timing
- Reset (`resetn`=0 at edge): state CLEAR, `ptr`=0, `q`=0, `q_addr`=0, `busy`=1, `wrap`=0. Memory contents not reset directly; cleared by sequence.
- After `resetn` rises: busy stays 1 for exactly DEPTH edges (writes addr 0..DEPTH-1), `busy`=0 from cycle DEPTH; first manual access accepted that cycle.
- Read latency 1: `address` sampled at edge t -> `q`/`q_addr` valid after edge t. In SCAN `q_addr`=`ptr` of previous cycle, same latency.
- During CLEAR `q`=0, `q_addr`=address being cleared.
- `resetn` low mid-CLEAR or mid-SCAN: restart CLEAR from address 0 next edge; full DEPTH-cycle sequence repeated.
- `clear_req` held high through CLEAR: single sequence; re-triggers only if still high in MANUAL.

## Structure
- Package `ram_sweep_pkg`: state encoding constants ST_CLEAR, ST_MANUAL, ST_SCAN (2-bit).
- Sub-module `ram_sweep_mem`: inferred single-port synchronous RAM, DATA_W x DEPTH, registered write-through read. Top holds FSM, `ptr`, dwell counter, address/data muxing.

## Test plan (DATA_W=8, ADDR_W=5, DWELL=4)
- Release reset -> `busy`=1 for 32 cycles then 0; reading 0..31 returns 0x00 each, `q_addr` matching one cycle later.
- MANUAL write 0xA5 to 0x13 -> next cycle `q`=0xA5, `q_addr`=0x13; later read of 0x13 returns 0xA5, 0x12 returns 0x00.
- Preload 0x00=0x11, 0x01=0x22, 0x1F=0x99; `scan_en`=1 -> `q_addr`=0x00/`q`=0x11 for 4 cycles, then 0x01/0x22 for 4; 0x1F/0x99 held 4 cycles, `wrap` pulses once, `q_addr` returns to 0x00 128 cycles after scan start.
- `wren`=1, `data`=0x5A, `address`=0x00 during SCAN -> mem[0x00] remains 0x11 after `scan_en`=0.
- `clear_req` pulse mid-scan with `scan_en` high -> `busy`=1 for 32 cycles, then one MANUAL cycle, then SCAN from 0x00 showing 0x00.
- `resetn` low for one cycle at clear cycle 10 -> `busy` stays high 32 further cycles after release; all words read 0x00.
